// File: rtl/joybus_device_responder.sv
`timescale 1ns/1ps
// N64 joybus device-side responder: decodes PIF command pulses from the synchronized
// line and answers info/reset (0x00/0xFF) and button-read (0x01) with timed reply frames.
module joybus_device_responder #(
    parameter int          CLK_PER_US  = 50,
    parameter logic [15:0] DEV_ID      = 16'h0500,
    parameter int          RESP_GAP_US = 2,
    parameter int          IDLE_US     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_in,
    output logic        joy_oe,
    input  logic [31:0] buttons,
    input  logic [7:0]  pak_status,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        busy
);

    localparam int TW = $clog2(IDLE_US * CLK_PER_US + 1);
    localparam logic [TW-1:0] T_1US  = TW'(CLK_PER_US);
    localparam logic [TW-1:0] T_2US  = TW'(2 * CLK_PER_US);
    localparam logic [TW-1:0] T_3US  = TW'(3 * CLK_PER_US);
    localparam logic [TW-1:0] T_LONG = TW'(5 * CLK_PER_US);
    localparam logic [TW-1:0] T_GAP  = TW'(RESP_GAP_US * CLK_PER_US);
    localparam logic [TW-1:0] T_IDLE = TW'(IDLE_US * CLK_PER_US);

    // state   | meaning
    // IDLE    | line idle, waiting for a host falling edge
    // RX_LOW  | measuring low part of a host pulse
    // RX_HIGH | measuring high part of a host pulse
    // DISCARD | ignoring the line until it stays high for IDLE_US
    // GAP     | line released before the reply
    // TX_LOW  | driving the low part of a reply bit
    // TX_HIGH | releasing for the high part of a reply bit
    // TX_STOP | driving the reply stop bit
    typedef enum logic [2:0] {
        IDLE, RX_LOW, RX_HIGH, DISCARD, GAP, TX_LOW, TX_HIGH, TX_STOP
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync2, line_d;
    logic [TW-1:0] timer, timer_n, timer_inc;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    cmd_sr, cmd_sr_n;
    logic [31:0]   tx_sr, tx_sr_n;
    logic [5:0]    tx_cnt, tx_cnt_n;
    logic [7:0]    cmd_code_n;
    logic          cmd_valid_n;
    logic          fall, rise, rx_bit;
    logic [TW-1:0] tx_low_len, tx_high_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_d    <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            tx_sr     <= '0;
            tx_cnt    <= '0;
            cmd_code  <= '0;
            cmd_valid <= 1'b0;
        end else begin
            sync1     <= joy_in;
            sync2     <= sync1;
            line_d    <= sync2;
            state     <= state_n;
            timer     <= timer_n;
            bit_cnt   <= bit_cnt_n;
            cmd_sr    <= cmd_sr_n;
            tx_sr     <= tx_sr_n;
            tx_cnt    <= tx_cnt_n;
            cmd_code  <= cmd_code_n;
            cmd_valid <= cmd_valid_n;
        end
    end

    // timer holds the number of samples already spent at the current level
    always_comb begin
        fall        = line_d & ~sync2;
        rise        = ~line_d & sync2;
        timer_inc   = (timer == '1) ? timer : timer + 1'b1;
        rx_bit      = (timer < T_2US);
        tx_low_len  = tx_sr[31] ? T_1US : T_3US;
        tx_high_len = tx_sr[31] ? T_3US : T_1US;

        state_n     = state;
        timer_n     = timer;
        bit_cnt_n   = bit_cnt;
        cmd_sr_n    = cmd_sr;
        tx_sr_n     = tx_sr;
        tx_cnt_n    = tx_cnt;
        cmd_code_n  = cmd_code;
        cmd_valid_n = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n   = RX_LOW;
                    timer_n   = 1;
                    bit_cnt_n = '0;
                end
            end
            RX_LOW: begin
                if (rise) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                    timer_n   = 1;
                    if (bit_cnt == 4'd8) begin
                        // 9th pulse is the host stop bit; its value is not kept
                        state_n = DISCARD;
                        if (cmd_sr == 8'h00 || cmd_sr == 8'hFF) begin
                            tx_sr_n  = {DEV_ID, pak_status, 8'h00};
                            tx_cnt_n = 6'd24;
                            state_n  = GAP;
                        end else if (cmd_sr == 8'h01) begin
                            tx_sr_n  = buttons;
                            tx_cnt_n = 6'd32;
                            state_n  = GAP;
                        end
                        if (state_n == GAP) begin
                            cmd_code_n  = cmd_sr;
                            cmd_valid_n = 1'b1;
                            timer_n     = '0;
                        end
                    end else begin
                        cmd_sr_n = {cmd_sr[6:0], rx_bit};
                        state_n  = RX_HIGH;
                    end
                end else if (timer_inc >= T_LONG) begin
                    state_n = DISCARD;
                    timer_n = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            RX_HIGH: begin
                if (fall) begin
                    state_n = RX_LOW;
                    timer_n = 1;
                end else begin
                    timer_n = timer_inc;
                    if (timer_inc >= T_LONG) state_n = DISCARD;
                end
            end
            DISCARD: begin
                if (!sync2) begin
                    timer_n = '0;
                end else if (timer_inc >= T_IDLE) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            GAP: begin
                if (timer_inc >= T_GAP) begin
                    state_n = TX_LOW;
                    timer_n = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            TX_LOW: begin
                if (timer_inc >= tx_low_len) begin
                    state_n = TX_HIGH;
                    timer_n = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            TX_HIGH: begin
                if (timer_inc >= tx_high_len) begin
                    timer_n  = '0;
                    tx_sr_n  = {tx_sr[30:0], 1'b0};
                    tx_cnt_n = tx_cnt - 6'd1;
                    state_n  = (tx_cnt == 6'd1) ? TX_STOP : TX_LOW;
                end else begin
                    timer_n = timer_inc;
                end
            end
            TX_STOP: begin
                if (timer_inc >= T_2US) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    assign joy_oe = (state == TX_LOW) || (state == TX_STOP);
    assign busy   = (state != IDLE);

endmodule
